// File: rtl/ultra_pkg.sv
// Shared definitions for the ultrasonic ranging peripheral: register offsets,
// CTRL/STATUS bit positions and the sequencing FSM encoding.
package ultra_pkg;

    localparam logic [2:0] OFS_CTRL  = 3'd0;
    localparam logic [2:0] OFS_DIST  = 3'd1;
    localparam logic [2:0] OFS_COUNT = 3'd2;

    localparam int CTRL_START  = 0;
    localparam int CTRL_CLEAR  = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int STAT_BUSY   = 0;
    localparam int STAT_DONE   = 1;
    localparam int STAT_TOUT   = 2;
    localparam int STAT_IRQ_EN = 3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_WAIT_ECHO = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_DONE      = 3'd4,
        ST_TOUT      = 3'd5
    } state_t;

endpackage

// File: rtl/ultra_io_periph_if.sv
// CPU IO bus between the host and the ranging peripheral.
interface ultra_io_periph_if;

    logic        io_rd_i;
    logic        io_wr_i;
    logic [15:0] io_addr_i;
    logic [15:0] io_dout_i;
    logic [15:0] io_din_o;

    modport master (output io_rd_i, output io_wr_i, output io_addr_i,
                    output io_dout_i, input io_din_o);

    modport slave  (input io_rd_i, input io_wr_i, input io_addr_i,
                    input io_dout_i, output io_din_o);

endinterface

// File: rtl/ultra_us_tick.sv
// Microsecond prescaler: one-cycle tick every CLK_MHZ clocks, realigned by restart.
module ultra_us_tick #(
    parameter int CLK_MHZ = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic us_tick
);

    localparam int            CW   = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
    localparam logic [CW-1:0] LOAD = CW'(CLK_MHZ - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (restart || cnt_q == '0) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign us_tick = (cnt_q == '0);

endmodule

// File: rtl/ultra_io_periph.sv
// Ultrasonic ranging peripheral: trigger pulse, echo timing in microseconds, timeouts.
// Optional interrupt output is built only when ULTRA_IRQ_EN is defined.
module ultra_io_periph
    import ultra_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = 16'h6700,
    parameter int          CLK_MHZ    = 50,
    parameter int          TRIG_US    = 10,
    parameter int          TIMEOUT_US = 30000
) (
    input  logic              sys_clk_i,
    input  logic              sys_rst_i,
    ultra_io_periph_if.slave  bus,
    output logic              trig_o,
    input  logic              echo_i
`ifdef ULTRA_IRQ_EN
    ,
    output logic              irq_o
`endif
);

    // state        | meaning
    // ST_IDLE      | waiting for a start write
    // ST_TRIG      | driving the trigger pin for TRIG_US
    // ST_WAIT_ECHO | waiting for echo rising edge, bounded by TIMEOUT_US
    // ST_MEASURE   | counting echo high time, bounded by TIMEOUT_US
    // ST_DONE      | one cycle: latch distance, set done
    // ST_TOUT      | one cycle: distance saturated, set done and timeout

    localparam logic [15:0] TRIG_LD = 16'(TRIG_US - 1);
    localparam logic [15:0] TOUT_LD = 16'(TIMEOUT_US - 1);

    state_t      state_q, state_d;
    logic [15:0] tmr_q, tmr_d;
    logic [15:0] meas_q, meas_d;
    logic [15:0] dist_q;
    logic [7:0]  count_q;
    logic        done_q, done_d;
    logic        tout_q, tout_d;
    logic        irq_en;
    logic        echo_s1, echo_s2, echo_d;
    logic        echo_rise, echo_fall;
    logic        us_tick, restart;
    logic        enter_done, enter_tout;
    logic        sel, wr_ctrl, start_req, clr_req, busy;
    logic [2:0]  ofs;

    assign sel       = (bus.io_addr_i[15:4] == BASE_ADDR[15:4]);
    assign ofs       = bus.io_addr_i[3:1];
    assign wr_ctrl   = bus.io_wr_i && sel && (ofs == OFS_CTRL);
    assign start_req = wr_ctrl && bus.io_dout_i[CTRL_START];
    assign clr_req   = wr_ctrl && bus.io_dout_i[CTRL_CLEAR];
    assign busy      = (state_q != ST_IDLE);
    assign trig_o    = (state_q == ST_TRIG);

    logic unused_bits;
    assign unused_bits = &{1'b0, bus.io_addr_i[0], bus.io_dout_i[15:3], BASE_ADDR[3:0]};

    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            echo_s1 <= 1'b0;
            echo_s2 <= 1'b0;
            echo_d  <= 1'b0;
        end else begin
            echo_s1 <= echo_i;
            echo_s2 <= echo_s1;
            echo_d  <= echo_s2;
        end
    end

    // echo_d tracks echo_s2 in every state, so a level already high on entry is not an edge
    assign echo_rise = echo_s2 && !echo_d;
    assign echo_fall = !echo_s2 && echo_d;

    ultra_us_tick #(.CLK_MHZ(CLK_MHZ)) u_us_tick (
        .clk     (sys_clk_i),
        .rst_n   (sys_rst_i),
        .restart (restart),
        .us_tick (us_tick)
    );

    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            meas_q  <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            meas_q  <= meas_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        meas_d  = meas_q;
        case (state_q)
            ST_IDLE: begin
                if (start_req) state_d = ST_TRIG;
            end
            ST_TRIG: begin
                if (us_tick) begin
                    if (tmr_q == '0) state_d = ST_WAIT_ECHO;
                    else             tmr_d   = tmr_q - 1'b1;
                end
            end
            ST_WAIT_ECHO: begin
                if (echo_rise) begin
                    state_d = ST_MEASURE;
                end else if (us_tick) begin
                    if (tmr_q == '0) state_d = ST_TOUT;
                    else             tmr_d   = tmr_q - 1'b1;
                end
            end
            ST_MEASURE: begin
                if (us_tick && meas_q != 16'hFFFF) meas_d = meas_q + 1'b1;
                if (echo_fall) begin
                    state_d = ST_DONE;
                end else if (us_tick) begin
                    if (tmr_q == '0) state_d = ST_TOUT;
                    else             tmr_d   = tmr_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // every state entry realigns the prescaler and reloads the state timer
        restart = (state_d != state_q);
        if (restart) begin
            case (state_d)
                ST_TRIG:      tmr_d = TRIG_LD;
                ST_WAIT_ECHO: tmr_d = TOUT_LD;
                ST_MEASURE:   tmr_d = TOUT_LD;
                default:      tmr_d = '0;
            endcase
            if (state_d == ST_MEASURE) meas_d = '0;
        end
    end

    assign enter_done = (state_q == ST_MEASURE) && (state_d == ST_DONE);
    assign enter_tout = (state_q != ST_TOUT) && (state_d == ST_TOUT);

    always_comb begin
        done_d = done_q;
        tout_d = tout_q;
        if (clr_req) begin
            done_d = 1'b0;
            tout_d = 1'b0;
        end
        if (enter_done) done_d = 1'b1;
        if (enter_tout) begin
            done_d = 1'b1;
            tout_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            done_q  <= 1'b0;
            tout_q  <= 1'b0;
            dist_q  <= '0;
            count_q <= '0;
        end else begin
            done_q <= done_d;
            tout_q <= tout_d;
            if (enter_done) dist_q <= meas_q;
            if (enter_tout) dist_q <= 16'hFFFF;
            if (enter_done || enter_tout) count_q <= count_q + 1'b1;
        end
    end

`ifdef ULTRA_IRQ_EN
    logic irq_en_d;

    always_comb begin
        irq_en_d = irq_en;
        if (wr_ctrl) irq_en_d = bus.io_dout_i[CTRL_IRQ_EN];
    end

    // irq follows the next-state flags so a clear write drops it on the same edge
    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            irq_en <= 1'b0;
            irq_o  <= 1'b0;
        end else begin
            irq_en <= irq_en_d;
            irq_o  <= done_d && irq_en_d;
        end
    end
`else
    assign irq_en = 1'b0;
`endif

    always_comb begin
        bus.io_din_o = '0;
        if (bus.io_rd_i && sel) begin
            case (ofs)
                OFS_CTRL:  bus.io_din_o = {12'h000, irq_en, tout_q, done_q, busy};
                OFS_DIST:  bus.io_din_o = dist_q;
                OFS_COUNT: bus.io_din_o = {8'h00, count_q};
                default:   bus.io_din_o = '0;
            endcase
        end
    end

endmodule

// File: doc/ultra_io_periph.md
ULTRA_IO_PERIPH -- requirements
Module: ultra_io_periph

Interface
REQ-001 Parameter BASE_ADDR, default 16'h6700, SHALL be the register block base; io_addr_i[15:4] is matched against BASE_ADDR[15:4].
REQ-002 Parameter CLK_MHZ, default 50, SHALL be the system clock frequency in MHz and set the 1 us prescaler.
REQ-003 Parameter TRIG_US, default 10, SHALL be the trigger pulse width in microseconds.
REQ-004 Parameter TIMEOUT_US, default 30000, SHALL be the maximum wait for echo rise, and separately for echo high time, in microseconds.
REQ-005 sys_clk_i  input  1  SHALL be the single clock; all logic is on its rising edge.
REQ-006 sys_rst_i  input  1  SHALL be the asynchronous, active-low reset.
REQ-007 io_rd_i  input  1  SHALL be the CPU IO read strobe.
REQ-008 io_wr_i  input  1  SHALL be the CPU IO write strobe.
REQ-009 io_addr_i  input  16  SHALL be the CPU IO address.
REQ-010 io_dout_i  input  16  SHALL be the CPU write data.
REQ-011 io_din_o  output  16  SHALL be the read data returned to the CPU.
REQ-012 trig_o  output  1  SHALL drive the sensor trigger pin.
REQ-013 echo_i  input  1  SHALL be the sensor echo pin; it is asynchronous.
REQ-014 irq_o  output  1  SHALL be the measurement-complete interrupt; it exists only per REQ-031.

Function
REQ-015 Register select SHALL be io_addr_i[15:4]==BASE_ADDR[15:4]; the word offset SHALL be io_addr_i[3:1].
- Offset 0: CTRL (write) / STATUS (read).
- Offset 1: DIST (read-only).
- Offset 2: COUNT (read-only).
- Other offsets: read 0, writes ignored.
REQ-016 io_din_o SHALL be combinational in the same cycle as io_rd_i; it SHALL be 16'h0000 when io_rd_i is low or the register is unselected.
REQ-017 A CTRL write SHALL act on the clock edge where io_wr_i is high and the register is selected.
- bit1: clear the done and timeout flags.
- bit0: start a measurement.
- If both are set, the clear SHALL apply first, then the start.
REQ-018 STATUS SHALL read {12'b0, irq_en, timeout, done, busy}, where busy = FSM not in IDLE.
REQ-019 echo_i SHALL pass through a 2-flop synchronizer before any use; edge detection SHALL use the synchronized value.
REQ-020 A prescaler SHALL produce a one-cycle us_tick every CLK_MHZ clocks; it SHALL restart from zero on every FSM state entry.
REQ-021 FSM states and transitions SHALL be:
- IDLE: start -> TRIG.
- TRIG: trig_o=1; after TRIG_US ticks -> WAIT_ECHO.
- WAIT_ECHO: synchronized echo rising edge -> MEASURE; TIMEOUT_US ticks -> TOUT.
- MEASURE: echo falling edge -> DONE; TIMEOUT_US ticks -> TOUT.
- DONE and TOUT: one cycle -> IDLE.
REQ-022 trig_o SHALL rise on the cycle after the start write and stay high for exactly TRIG_US*CLK_MHZ cycles (±1).
REQ-023 In MEASURE, a 16-bit microsecond counter SHALL increment per us_tick and saturate at 16'hFFFF without wrapping.
REQ-024 On entry to DONE, DIST SHALL be loaded with the counter value and done SHALL be set.
REQ-025 On entry to TOUT, DIST SHALL be 16'hFFFF and both done and timeout SHALL be set.
REQ-026 COUNT SHALL be an 8-bit value, zero-extended on read, that increments on each DONE or TOUT entry and wraps 255->0.
REQ-027 A start write while busy SHALL be ignored; a clear write while busy SHALL still clear the flags.
REQ-028 An echo already high on entry to WAIT_ECHO SHALL NOT count as a rising edge.

Reset
REQ-029 While sys_rst_i=0, the following SHALL hold asynchronously:
- FSM in IDLE.
- trig_o=0 and irq_o=0.
- DIST=0, COUNT=0, done=0, timeout=0, irq_en=0.
- Synchronizer, prescaler and counter cleared.
REQ-030 A reset asserted mid-measurement SHALL abort it with no COUNT or DIST update.

Configuration
REQ-031 With ULTRA_IRQ_EN defined:
- CTRL bit2 SHALL write irq_en.
- irq_o SHALL be a registered output equal to done & irq_en.
Without ULTRA_IRQ_EN:
- The irq_o port SHALL be absent.
- irq_en SHALL read 0.
- CTRL bit2 SHALL be ignored.

Structure
REQ-032 Package ultra_pkg SHALL hold the register offsets, the CTRL/STATUS bit indices and the FSM state encoding.
REQ-033 The prescaler SHALL be a sub-module ultra_us_tick, with parameter CLK_MHZ and inputs clk, rst_n and restart.

Verification
REQ-034 Reset-state read: read STATUS, DIST and COUNT after reset -> all 16'h0000; trig_o=0.
REQ-035 Normal measurement: write CTRL=16'h0001; echo rises 20 us later and stays high 580 us -> DIST=580±1, STATUS=16'h0002, COUNT=1, trig_o high for 500 cycles.
REQ-036 Echo-rise timeout: no echo after start -> after 30010 us, STATUS=16'h0006 and DIST=16'hFFFF.
REQ-037 Start while busy plus clear: start, then a second start 5 us later is ignored (single trigger pulse); afterwards write CTRL=16'h0003 -> done cleared, new measurement starts.
REQ-038 Unselected access and mid-measurement reset: read address 16'h6710 -> io_din_o=0; assert reset mid-MEASURE -> IDLE, COUNT unchanged at 0.
REQ-039 IRQ (with ULTRA_IRQ_EN): write CTRL=16'h0005, complete a measurement -> irq_o=1; write 16'h0006 -> irq_o=0 next cycle.
